rock_swing_monitor: RTL and testbench



---
 rtl/rock_swing_monitor_if.sv | 26 ++
 rtl/rock_swing_monitor.sv | 162 ++++++++++++++++
 tb/tb_rock_swing_monitor.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rock_swing_monitor_if.sv
// Sample stream in, swing measurements and adjustment requests out.
// master: sensor/sequencer side; slave: the swing monitor.
interface rock_swing_monitor_if #(
  parameter int SAMPLE_W = 8,
  parameter int PER_W    = 12
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       Fhoog;
  logic                       Flaag;
  logic                       Alaag;
  logic                       swing_done;
  logic [PER_W-1:0]           period;
  logic [SAMPLE_W-1:0]        peak;
  logic                       stalled;

  modport master (
    output sample_valid, sample,
    input  Fhoog, Flaag, Alaag, swing_done, period, peak, stalled
  );

  modport slave (
    input  sample_valid, sample,
    output Fhoog, Flaag, Alaag, swing_done, period, peak, stalled
  );
endinterface

// File: rtl/rock_swing_monitor.sv
// Measures cradle swing period and peak amplitude between upward zero crossings
// and issues one-cycle frequency/amplitude adjustment requests.
//
// state   | meaning
// SYNC    | waiting for the first upward crossing, nothing measured yet
// MEASURE | timing a swing; requests allowed when it completes
// HOLD    | timing a swing; requests suppressed until hold_q swings have passed
module rock_swing_monitor #(
  parameter int SAMPLE_W = 8,
  parameter int PER_W    = 12,
  parameter int PER_MIN  = 400,
  parameter int PER_MAX  = 600,
  parameter int AMP_MIN  = 40,
  parameter int HOLDOFF  = 2,
  parameter int TIMEOUT  = 4000
) (
  input logic           clk,
  input logic           reset,
  rock_swing_monitor_if.slave mon
);

  localparam int HW = $clog2(HOLDOFF + 2);
  localparam logic [PER_W-1:0]    PER_MIN_C = PER_W'(PER_MIN);
  localparam logic [PER_W-1:0]    PER_MAX_C = PER_W'(PER_MAX);
  localparam logic [PER_W-1:0]    TIMEOUT_C = PER_W'(TIMEOUT);
  localparam logic [SAMPLE_W-1:0] AMP_MIN_C = SAMPLE_W'(AMP_MIN);
  localparam logic [HW-1:0]       HOLDOFF_C = HW'(HOLDOFF);
  localparam logic [SAMPLE_W-1:0] MOST_NEG  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MAG_MAX   = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [1:0] {SYNC, MEASURE, HOLD} state_t;

  state_t              state_q, state_d;
  logic                prev_neg_q, prev_neg_d;
  logic [PER_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [PER_W-1:0]    period_q, period_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic                stalled_q, stalled_d;
  logic                done_q, done_d;
  logic                fhoog_q, fhoog_d;
  logic                flaag_q, flaag_d;
  logic                alaag_q, alaag_d;

  logic [SAMPLE_W-1:0] mag;
  logic [PER_W-1:0]    cnt_inc;
  logic                crossing;
  logic                req_fh, req_fl, req_al;

  // Saturate the most-negative sample so the magnitude fits the signed range.
  always_comb begin
    mag = mon.sample;
    if (mon.sample[SAMPLE_W-1]) begin
      if (mon.sample == MOST_NEG) mag = MAG_MAX;
      else                        mag = ~mon.sample + SAMPLE_W'(1);
    end
  end

  assign crossing = mon.sample_valid & prev_neg_q & ~mon.sample[SAMPLE_W-1];
  assign cnt_inc  = cnt_q + PER_W'(1);
  assign req_fh   = cnt_q < PER_MIN_C;
  assign req_fl   = cnt_q > PER_MAX_C;
  assign req_al   = acc_q < AMP_MIN_C;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC;
      prev_neg_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      hold_q     <= '0;
      period_q   <= '0;
      peak_q     <= '0;
      stalled_q  <= 1'b0;
      done_q     <= 1'b0;
      fhoog_q    <= 1'b0;
      flaag_q    <= 1'b0;
      alaag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_neg_q <= prev_neg_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      hold_q     <= hold_d;
      period_q   <= period_d;
      peak_q     <= peak_d;
      stalled_q  <= stalled_d;
      done_q     <= done_d;
      fhoog_q    <= fhoog_d;
      flaag_q    <= flaag_d;
      alaag_q    <= alaag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_neg_d = prev_neg_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    hold_d     = hold_q;
    period_d   = period_q;
    peak_d     = peak_q;
    stalled_d  = stalled_q;
    done_d     = 1'b0;
    fhoog_d    = 1'b0;
    flaag_d    = 1'b0;
    alaag_d    = 1'b0;
    if (mon.sample_valid) begin
      prev_neg_d = mon.sample[SAMPLE_W-1];
      case (state_q)
        SYNC: begin
          if (crossing) begin
            cnt_d     = PER_W'(1);
            acc_d     = mag;
            stalled_d = 1'b0;
            state_d   = MEASURE;
          end
        end
        default: begin
          if (crossing) begin
            period_d = cnt_q;
            peak_d   = acc_q;
            done_d   = 1'b1;
            cnt_d    = PER_W'(1);
            acc_d    = mag;
            if (state_q == HOLD) begin
              hold_d = hold_q - HW'(1);
              if (hold_q == HW'(1)) state_d = MEASURE;
            end else begin
              fhoog_d = req_fh;
              flaag_d = req_fl;
              alaag_d = req_al;
              if ((req_fh | req_fl | req_al) && (HOLDOFF > 0)) begin
                hold_d  = HOLDOFF_C;
                state_d = HOLD;
              end
            end
          end else if (cnt_inc >= TIMEOUT_C) begin
            // Stall: report low amplitude even while holding off, then resync.
            stalled_d = 1'b1;
            alaag_d   = 1'b1;
            hold_d    = '0;
            state_d   = SYNC;
          end else begin
            cnt_d = cnt_inc;
            if (mag > acc_q) acc_d = mag;
          end
        end
      endcase
    end
  end

  assign mon.Fhoog      = fhoog_q;
  assign mon.Flaag      = flaag_q;
  assign mon.Alaag      = alaag_q;
  assign mon.swing_done = done_q;
  assign mon.period     = period_q;
  assign mon.peak       = peak_q;
  assign mon.stalled    = stalled_q;

endmodule

// File: tb/tb_rock_swing_monitor.sv
// Scoreboard bench for rock_swing_monitor: a behavioural swing model queues
// expected output events as samples are driven; a negedge monitor pops and compares.
module tb_rock_swing_monitor;
  localparam int SAMPLE_W = 8;
  localparam int PER_W    = 12;
  localparam int PER_MIN  = 400;
  localparam int PER_MAX  = 600;
  localparam int AMP_MIN  = 40;
  localparam int HOLDOFF  = 2;
  localparam int TIMEOUT  = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rock_swing_monitor_if #(.SAMPLE_W(SAMPLE_W), .PER_W(PER_W)) bus ();

  rock_swing_monitor #(
    .SAMPLE_W(SAMPLE_W), .PER_W(PER_W), .PER_MIN(PER_MIN), .PER_MAX(PER_MAX),
    .AMP_MIN(AMP_MIN), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (bus)
  );

  typedef struct {
    int done;
    int fh;
    int fl;
    int al;
    int period;
    int peak;
    int stalled;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // model state
  bit m_sync, m_prevneg;
  int m_cnt, m_acc, m_hold, m_period, m_peak, m_stalled;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 1; m_prevneg = 0; m_cnt = 0; m_acc = 0; m_hold = 0;
    m_period = 0; m_peak = 0; m_stalled = 0;
    sb.delete();
  endtask

  task automatic model_step(input int s);
    int   mag;
    bit   up;
    exp_t e;
    mag = (s < 0) ? ((-s > 127) ? 127 : -s) : s;
    up = m_prevneg && (s >= 0);
    m_prevneg = (s < 0);
    if (m_sync) begin
      if (up) begin
        m_sync = 0; m_cnt = 1; m_acc = mag; m_stalled = 0;
      end
    end else if (up) begin
      e = '{done:1, fh:0, fl:0, al:0, period:m_cnt, peak:m_acc, stalled:m_stalled, cyc:cyc + 1};
      if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end else begin
        e.fh = (m_cnt < PER_MIN) ? 1 : 0;
        e.fl = (m_cnt > PER_MAX) ? 1 : 0;
        e.al = (m_acc < AMP_MIN) ? 1 : 0;
        if (e.fh + e.fl + e.al > 0) m_hold = HOLDOFF;
      end
      m_period = m_cnt; m_peak = m_acc;
      m_cnt = 1; m_acc = mag;
      sb.push_back(e);
    end else begin
      m_cnt = m_cnt + 1;
      if (mag > m_acc) m_acc = mag;
      if (m_cnt >= TIMEOUT) begin
        e = '{done:0, fh:0, fl:0, al:1, period:m_period, peak:m_peak, stalled:1, cyc:cyc + 1};
        sb.push_back(e);
        m_sync = 1; m_hold = 0; m_stalled = 1;
      end
    end
  endtask

  // Every cycle carrying a pulse must match the next queued event, at the predicted cycle.
  always @(negedge clk) begin
    if (!reset && (bus.swing_done || bus.Fhoog || bus.Flaag || bus.Alaag)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        check("latency",    cyc,            got.cyc);
        check("swing_done", bus.swing_done, got.done);
        check("Fhoog",      bus.Fhoog,      got.fh);
        check("Flaag",      bus.Flaag,      got.fl);
        check("Alaag",      bus.Alaag,      got.al);
        check("period",     bus.period,     got.period);
        check("peak",       bus.peak,       got.peak);
        check("stalled",    bus.stalled,    got.stalled);
      end
    end
  end

  task automatic drive(input int v, input int gap);
    bus.sample_valid = 1'b1;
    bus.sample = SAMPLE_W'(v);
    model_step(v);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic half(input int n, input int v, input int gap);
    for (int i = 0; i < n; i++) drive(v, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_outs"}, {bus.swing_done, bus.Fhoog, bus.Flaag, bus.Alaag, bus.stalled}, 32'd0);
    check({tag, "_period"}, bus.period, 32'd0);
    check({tag, "_peak"}, bus.peak, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    bus.sample_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string tag);
    idle(4);
    check({tag, "_drained"}, sb.size(), 32'd0);
  endtask

  // sync half-cycle followed by n full swings of neg/pos halves
  task automatic swings(input int nneg, input int npos, input int amp, input int n, input int gap);
    half(nneg, -amp, gap);
    half(npos, amp, gap);
    for (int k = 0; k < n; k++) begin
      half(nneg, -amp, gap);
      half(npos, amp, gap);
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    apply_reset();
    check_all_zero("reset");

    // baseline: period 500, peak 50, no requests
    half(250, -50, 0); half(250, 50, 0);
    for (int k = 0; k < 3; k++) begin half(250, -50, 0); half(250, 50, 0); end
    drain("baseline");

    // frequency too high with holdoff
    apply_reset();
    swings(150, 150, 60, 5, 0);
    drain("fast");

    // amplitude too low
    apply_reset();
    swings(250, 250, 20, 2, 0);
    drain("amp_low");

    // stall then resync
    apply_reset();
    swings(250, 250, 50, 1, 0);
    half(3800, 10, 0);
    drain("stall");
    @(negedge clk);
    check("stalled_level", bus.stalled, 32'd1);
    @(posedge clk); #1;
    drive(-10, 0); drive(10, 0);
    idle(2);
    @(negedge clk);
    check("stalled_clear", bus.stalled, 32'd0);
    @(posedge clk); #1;
    drain("resync");

    // boundaries: period 400, period 600, peak 40, saturated -128
    apply_reset(); swings(200, 200, 50, 1, 0); drain("per_min");
    apply_reset(); swings(300, 300, 50, 1, 0); drain("per_max");
    apply_reset(); swings(250, 250, 40, 1, 0); drain("amp_min");
    apply_reset();
    half(250, -50, 0); half(250, 50, 0);
    half(100, -50, 0); drive(-128, 0); half(149, -50, 0);
    half(250, 50, 0);
    half(1, -50, 0); half(1, 50, 0);
    drain("neg_sat");

    // gaps between samples
    apply_reset();
    swings(250, 250, 50, 1, 3);
    drain("gaps");

    // reset mid-swing
    half(100, -50, 0);
    apply_reset();
    check_all_zero("mid_reset");
    half(250, 50, 0);
    half(250, -50, 0); half(250, 50, 0);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
